// File: rtl/audio_uart_pkg.sv
// Shared FSM encoding and framing constants for audio_uart_tx.
// The parity state and helper exist only when AUDIO_UART_TX_PARITY_EN is defined.
package audio_uart_pkg;

`ifdef AUDIO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  function automatic logic even_parity(input logic [8:0] word);
    return ^word;
  endfunction
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } state_t;
`endif

  // One bit is enough to count up to two stop bits.
  localparam int STOP_CNT_W = 1;

endpackage

// File: rtl/audio_uart_fifo.sv
// Transmit word FIFO for audio_uart_tx: power-of-two depth, pointers wrap
// naturally, simultaneous push and pop keep the occupancy unchanged.
module audio_uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/audio_uart_tx.sv
// Buffered UART transmitter: FIFO-fed, LSB first, 1 or 2 stop bits, zero-gap
// back-to-back frames. Even parity bit is added when AUDIO_UART_TX_PARITY_EN is defined.
module audio_uart_tx
  import audio_uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_serial,
  output logic              o_busy
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_W);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BAUD_W-1:0]     BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]      LAST_BIT    = BIT_W'(DATA_W - 1);
  localparam logic [STOP_CNT_W-1:0] LAST_STOP   = STOP_CNT_W'(STOP_BITS - 1);

  state_t                  state;
  logic [BAUD_W-1:0]       baud;
  logic [BIT_W-1:0]        bit_idx;
  logic [STOP_CNT_W-1:0]   stop_idx;
  logic [DATA_W-1:0]       shift;
  logic                    alive;
`ifdef AUDIO_UART_TX_PARITY_EN
  logic                    parity_bit;
`endif

  logic                    push;
  logic                    pop;
  logic                    last_stop;
  logic [DATA_W-1:0]       head;
  logic                    full;
  logic                    empty;
  logic [CNT_W-1:0]        count;

  // alive gates o_ready so acceptance only starts on the first edge after reset.
  assign o_ready = alive && !full;
  assign push    = i_valid && o_ready;
  assign o_busy  = (state != IDLE) || (count != '0);

  always_comb begin
    last_stop = 1'b0;
    pop       = 1'b0;
    if ((state == STOP) && (baud == '0) && (stop_idx == LAST_STOP)) begin
      last_stop = 1'b1;
    end else begin
      last_stop = 1'b0;
    end
    if (!empty && ((state == IDLE) || last_stop)) begin
      pop = 1'b1;
    end else begin
      pop = 1'b0;
    end
  end

  audio_uart_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (push),
    .pop   (pop),
    .wdata (i_data),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      alive <= 1'b0;
    end else begin
      alive <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      baud     <= '0;
      bit_idx  <= '0;
      stop_idx <= '0;
      shift    <= '0;
      o_serial <= 1'b1;
`ifdef AUDIO_UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shift    <= head;
`ifdef AUDIO_UART_TX_PARITY_EN
            parity_bit <= even_parity(9'(head));
`endif
            state    <= START;
            o_serial <= 1'b0;
            baud     <= BAUD_RELOAD;
          end else begin
            o_serial <= 1'b1;
          end
        end
        START: begin
          if (baud == '0) begin
            state    <= DATA;
            o_serial <= shift[0];
            bit_idx  <= '0;
            baud     <= BAUD_RELOAD;
          end else begin
            baud <= baud - BAUD_W'(1);
          end
        end
        DATA: begin
          if (baud == '0) begin
            baud <= BAUD_RELOAD;
            if (bit_idx == LAST_BIT) begin
`ifdef AUDIO_UART_TX_PARITY_EN
              state    <= PARITY;
              o_serial <= parity_bit;
`else
              state    <= STOP;
              o_serial <= 1'b1;
              stop_idx <= '0;
`endif
            end else begin
              shift    <= shift >> 1;
              o_serial <= shift[1];
              bit_idx  <= bit_idx + BIT_W'(1);
            end
          end else begin
            baud <= baud - BAUD_W'(1);
          end
        end
`ifdef AUDIO_UART_TX_PARITY_EN
        PARITY: begin
          if (baud == '0) begin
            state    <= STOP;
            o_serial <= 1'b1;
            stop_idx <= '0;
            baud     <= BAUD_RELOAD;
          end else begin
            baud <= baud - BAUD_W'(1);
          end
        end
`endif
        STOP: begin
          if (baud == '0) begin
            if (stop_idx == LAST_STOP) begin
              // A queued word starts on the same edge the last stop bit ends.
              if (pop) begin
                shift    <= head;
`ifdef AUDIO_UART_TX_PARITY_EN
                parity_bit <= even_parity(9'(head));
`endif
                state    <= START;
                o_serial <= 1'b0;
                baud     <= BAUD_RELOAD;
              end else begin
                state    <= IDLE;
                o_serial <= 1'b1;
              end
            end else begin
              stop_idx <= stop_idx + STOP_CNT_W'(1);
              baud     <= BAUD_RELOAD;
            end
          end else begin
            baud <= baud - BAUD_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          o_serial <= 1'b1;
          baud     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_audio_uart_tx.sv
// Directed self-checking bench for audio_uart_tx (8 data bits, 4 clocks/bit);
// instance a uses one stop bit, instance b uses two stop bits.
module tb_audio_uart_tx;

  localparam int CPB = 4;
`ifdef AUDIO_UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB      = 10 + P;
  localparam int FRAME   = NB * CPB;
  localparam int FRAME_B = (NB + 1) * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_a = 8'h00;
  logic       valid_a = 1'b0;
  logic       ready_a, serial_a, busy_a;
  logic [7:0] data_b = 8'h00;
  logic       valid_b = 1'b0;
  logic       ready_b, serial_b, busy_b;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  audio_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_data(data_a), .i_valid(valid_a),
    .o_ready(ready_a), .o_serial(serial_a), .o_busy(busy_a)
  );

  audio_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_data(data_b), .i_valid(valid_b),
    .o_ready(ready_b), .o_serial(serial_b), .o_busy(busy_b)
  );

  // Expected line bits for one-stop-bit frames: [0]=start, data LSB first, [parity], stop.
  function automatic logic [10:0] frame_bits(input logic [7:0] w);
`ifdef AUDIO_UART_TX_PARITY_EN
    return {1'b1, ^w, w, 1'b0};
`else
    return {2'b01, w, 1'b0};
`endif
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (serial_a !== 1'b1 || serial_b !== 1'b1) $display("FAIL reset_serial: got %b/%b expected 1/1", serial_a, serial_b);
    else passed++;
    checks++;
    if (ready_a !== 1'b0) $display("FAIL reset_ready: got %b expected 0", ready_a);
    else passed++;
    checks++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0) $display("FAIL reset_busy: got %b/%b expected 0/0", busy_a, busy_b);
    else passed++;
    rst = 1'b0;
    #1;
    checks++;
    if (ready_a !== 1'b0) $display("FAIL reset_release_ready_early: got %b expected 0", ready_a);
    else passed++;
    @(negedge clk);
    checks++;
    if (ready_a !== 1'b1 || ready_b !== 1'b1) $display("FAIL reset_release_ready: got %b/%b expected 1/1", ready_a, ready_b);
    else passed++;
  endtask

  task automatic test_frame(input logic [7:0] w, input string name, output logic [10:0] seen);
    logic [10:0] exp_bits;
    logic        bad;
    logic        got;
    exp_bits = frame_bits(w);
    seen = '0;
    @(negedge clk);
    data_a = w;
    valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    checks++;
    if (serial_a !== 1'b1) $display("FAIL %s_latency: serial %b before start edge, expected 1", name, serial_a);
    else passed++;
    for (int b = 0; b < NB; b++) begin
      bad = 1'b0;
      got = 1'b0;
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        seen[b] = serial_a;
        if (serial_a !== exp_bits[b]) begin
          bad = 1'b1;
          got = serial_a;
        end
      end
      checks++;
      if (bad) $display("FAIL %s_bit%0d: serial %b expected %b", name, b, got, exp_bits[b]);
      else passed++;
    end
    @(negedge clk);
    checks++;
    if (serial_a !== 1'b1 || busy_a !== 1'b0)
      $display("FAIL %s_end: serial %b busy %b expected 1 0", name, serial_a, busy_a);
    else passed++;
  endtask

`ifdef AUDIO_UART_TX_PARITY_EN
  task automatic test_parity();
    logic [10:0] seen;
    test_frame(8'hA5, "par_a5", seen);
    checks++;
    if (seen[9] !== 1'b0) $display("FAIL parity_a5: got %b expected 0", seen[9]);
    else passed++;
    test_frame(8'h01, "par_01", seen);
    checks++;
    if (seen[9] !== 1'b1) $display("FAIL parity_01: got %b expected 1", seen[9]);
    else passed++;
  endtask
`endif

  task automatic test_back_to_back();
    logic [7:0]  words [6];
    logic        samples [6*FRAME];
    logic [10:0] exp_bits;
    logic        bad;
    logic        occ_bad;
    int          waited;
    int          bad_idx;
    words[0] = 8'h3C; words[1] = 8'h11; words[2] = 8'h22;
    words[3] = 8'h33; words[4] = 8'h44; words[5] = 8'h55;
    occ_bad = 1'b0;
    waited = 0;
    @(negedge clk);
    data_a = words[0];
    valid_a = 1'b1;
    @(negedge clk);
    fork
      begin
        for (int k = 0; k < 6*FRAME; k++) begin
          @(negedge clk);
          samples[k] = serial_a;
        end
      end
      begin
        for (int i = 1; i < 6; i++) begin
          data_a = words[i];
          valid_a = 1'b1;
          waited = 0;
          while (!ready_a && waited < 400) begin
            if (u_dut.u_fifo.count !== 3'd4) occ_bad = 1'b1;
            @(negedge clk);
            waited++;
          end
          @(negedge clk);
          if (i == 4) begin
            checks++;
            if (ready_a !== 1'b0) $display("FAIL b2b_ready_after_4th: got %b expected 0", ready_a);
            else passed++;
          end
        end
        valid_a = 1'b0;
      end
    join
    checks++;
    if (waited != FRAME - 3) $display("FAIL b2b_5th_hold: waited %0d cycles expected %0d", waited, FRAME - 3);
    else passed++;
    checks++;
    if (occ_bad) $display("FAIL b2b_occupancy_hold: count left 4 while o_ready low, expected 4");
    else passed++;
    for (int f = 0; f < 6; f++) begin
      exp_bits = frame_bits(words[f]);
      bad = 1'b0;
      bad_idx = 0;
      for (int c = 0; c < FRAME; c++) begin
        if (!bad && samples[f*FRAME + c] !== exp_bits[c / CPB]) begin
          bad = 1'b1;
          bad_idx = c;
        end
      end
      checks++;
      if (bad) $display("FAIL b2b_frame%0d: cycle %0d serial %b expected %b", f, bad_idx,
                        samples[f*FRAME + bad_idx], exp_bits[bad_idx / CPB]);
      else passed++;
    end
    @(negedge clk);
    checks++;
    if (serial_a !== 1'b1 || busy_a !== 1'b0)
      $display("FAIL b2b_end: serial %b busy %b expected 1 0", serial_a, busy_a);
    else passed++;
  endtask

  task automatic test_stop2();
    logic s2 [2*FRAME_B + 2];
    logic bad;
    int   run;
    int   k;
    @(negedge clk);
    data_b = 8'h00;
    valid_b = 1'b1;
    @(negedge clk);
    @(negedge clk);
    valid_b = 1'b0;
    s2[0] = 1'b1;
    s2[1] = serial_b;
    for (int i = 2; i < 2*FRAME_B + 2; i++) begin
      @(negedge clk);
      s2[i] = serial_b;
    end
    bad = 1'b0;
    for (int i = 1; i <= 36 + 4*P; i++) if (s2[i] !== 1'b0) bad = 1'b1;
    checks++;
    if (bad) $display("FAIL stop2_start_data: a nonzero bit in start/data of 0x00, expected all 0");
    else passed++;
    run = 0;
    k = 37 + 4*P;
    while (k < 2*FRAME_B + 2 && s2[k] === 1'b1) begin
      run++;
      k++;
    end
    checks++;
    if (run != 8) $display("FAIL stop2_high_run: %0d cycles high expected 8", run);
    else passed++;
    checks++;
    if (s2[2*FRAME_B + 1] !== 1'b1 || busy_b !== 1'b0)
      $display("FAIL stop2_end: serial %b busy %b expected 1 0", s2[2*FRAME_B + 1], busy_b);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic bad;
    @(negedge clk);
    data_a = 8'h5A;
    valid_a = 1'b1;
    @(negedge clk);
    data_a = 8'h66;
    @(negedge clk);
    data_a = 8'h77;
    @(negedge clk);
    valid_a = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (serial_a !== 1'b1 || busy_a !== 1'b0 || ready_a !== 1'b0)
      $display("FAIL rst_mid_immediate: serial %b busy %b ready %b expected 1 0 0", serial_a, busy_a, ready_a);
    else passed++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (ready_a !== 1'b0) $display("FAIL rst_mid_ready_early: got %b expected 0", ready_a);
    else passed++;
    @(negedge clk);
    checks++;
    if (ready_a !== 1'b1) $display("FAIL rst_mid_ready_after: got %b expected 1", ready_a);
    else passed++;
    bad = 1'b0;
    for (int i = 0; i < 3*FRAME; i++) begin
      @(negedge clk);
      if (serial_a !== 1'b1 || busy_a !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) $display("FAIL rst_mid_quiet: line left idle or busy rose after reset, expected serial 1 busy 0");
    else passed++;
  endtask

  initial begin
    logic [10:0] seen;
    test_reset();
    test_frame(8'hA5, "a5", seen);
    test_frame(8'h00, "x00", seen);
    test_frame(8'hFF, "xff", seen);
    test_frame(8'h81, "x81", seen);
`ifdef AUDIO_UART_TX_PARITY_EN
    test_parity();
`endif
    test_back_to_back();
    test_stop2();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
